// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and the divider FSM state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_FLAG_Z = 2'd0,
        ALU_FLAG_C = 2'd1,
        ALU_FLAG_V = 2'd2,
        ALU_FLAG_S = 2'd3
    } alu_flag_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [3:0] alu_make_flags(input logic z, input logic c,
                                                  input logic v, input logic s);
        logic [3:0] f;
        f             = '0;
        f[ALU_FLAG_Z] = z;
        f[ALU_FLAG_C] = c;
        f[ALU_FLAG_V] = v;
        f[ALU_FLAG_S] = s;
        return f;
    endfunction

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module alu_div_step (
    input  logic [7:0] prem,
    input  logic       in_bit,
    input  logic [7:0] divisor,
    output logic [7:0] new_prem,
    output logic       q_bit
);

    logic [8:0] t;

    always_comb begin
        t     = {prem, in_bit};
        q_bit = (t >= {1'b0, divisor});
        // prem < divisor on entry, so the difference always fits in 8 bits
        new_prem = q_bit ? (t[7:0] - divisor) : t[7:0];
    end

endmodule

// File: rtl/alu_div_seq.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock.
// Overflow and divide-by-zero short-circuit to DONE and return the dividend unchanged.
module alu_div_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags,
    output logic        div_zero
);

    div_state_e  state_q, state_d;
    logic [7:0]  prem_q, prem_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  divisor_q, divisor_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;

    logic [7:0]  step_prem;
    logic        step_q;
    logic [7:0]  quot;

    alu_div_step u_step (
        .prem     (prem_q),
        .in_bit   (sh_q[7]),
        .divisor  (divisor_q),
        .new_prem (step_prem),
        .q_bit    (step_q)
    );

    // sh_q starts as the low dividend byte and fills with quotient bits from the LSB
    assign quot = {sh_q[6:0], step_q};

    always_comb begin
        state_d    = state_q;
        prem_d     = prem_q;
        sh_d       = sh_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        result_d   = result_q;
        flags_d    = flags_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    divisor_d = divisor;
                    // Zero check first so the compare below never sees a zero divisor
                    if (divisor == 8'd0) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        div_zero_d = 1'b1;
                        result_d   = dividend;
                        flags_d    = alu_make_flags(1'b0, 1'b0, 1'b1, 1'b1);
                    end else if (dividend[15:8] >= divisor) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = dividend;
                        flags_d  = alu_make_flags(1'b0, 1'b0, 1'b1, 1'b1);
                    end else begin
                        state_d = RUN;
                        prem_d  = dividend[15:8];
                        sh_d    = dividend[7:0];
                        cnt_d   = 3'd7;
                    end
                end
            end
            RUN: begin
                prem_d = step_prem;
                sh_d   = quot;
                cnt_d  = cnt_q - 3'd1;
                if (cnt_q == 3'd0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = {step_prem, quot};
                    flags_d  = alu_make_flags(quot == 8'd0, 1'b0, 1'b0, quot[7]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            prem_q     <= '0;
            sh_q       <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            prem_q     <= prem_d;
            sh_q       <= sh_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign result   = result_q;
    assign flags    = flags_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: the driver queues expected responses, a monitor checks each done.
module tb_alu_div_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        div_zero;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   prev_done = 1'b0;

    // Flag nibble is {S, V, C, Z}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_Z    = 4'b0001;
    localparam logic [3:0] F_S    = 4'b1000;
    localparam logic [3:0] F_OVF  = 4'b1100;

    alu_div_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flags    (flags),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (done) begin
                if (prev_done) chk("done_single_cycle", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".result"}, {16'd0, result}, {16'd0, e.res});
                    chk({e.name, ".flags"}, {28'd0, flags}, {28'd0, e.flg});
                    chk({e.name, ".div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
                    chk({e.name, ".latency_cycle"}, cyc, e.cyc);
                    chk({e.name, ".busy_in_done"}, {31'd0, busy}, 32'd1);
                end
            end else if (div_zero) begin
                chk("div_zero_without_done", 32'd1, 32'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Ends on a negedge with busy low, or reports a timeout.
    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, ".idle_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic issue(input string nm, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] er, input logic [3:0] ef, input logic edz,
                         input bit fast);
        exp_t e;
        wait_idle(nm);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        e.name = nm;
        e.res  = er;
        e.flg  = ef;
        e.dz   = edz;
        e.cyc  = cyc + 1 + (fast ? 0 : 8);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int   s;
        exp_t e;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done}, 32'd0);
        chk("reset.result", {16'd0, result}, 32'd0);
        chk("reset.flags", {28'd0, flags}, 32'd0);
        chk("reset.div_zero", {31'd0, div_zero}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue("t1_1234_56", 16'h1234, 8'h56, 16'h1036, F_NONE, 1'b0, 1'b0);
        issue("t2_feff_ff", 16'hFEFF, 8'hFF, 16'hFEFF, F_S, 1'b0, 1'b0);
        issue("t3_0005_07", 16'h0005, 8'h07, 16'h0500, F_Z, 1'b0, 1'b0);
        issue("t3_ovf_5600_56", 16'h5600, 8'h56, 16'h5600, F_OVF, 1'b0, 1'b1);
        issue("t4_div0", 16'h1234, 8'h00, 16'h1234, F_OVF, 1'b1, 1'b1);

        // start held high: one divide per IDLE visit, operands changed mid-divide ignored
        wait_idle("held");
        dividend = 16'h1234;
        divisor  = 8'h56;
        start    = 1'b1;
        s = cyc + 1;
        e.name = "held_a"; e.res = 16'h1036; e.flg = F_NONE; e.dz = 1'b0; e.cyc = s + 8;
        sb.push_back(e);
        @(negedge clk);
        repeat (2) @(negedge clk);
        dividend = 16'hFEFF;
        divisor  = 8'hFF;
        repeat (7) @(negedge clk);
        e.name = "held_b"; e.res = 16'hFEFF; e.flg = F_S; e.dz = 1'b0; e.cyc = s + 18;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;

        // Reset in the middle of a normal divide
        issue("aborted", 16'h1234, 8'h56, 16'h1036, F_NONE, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset.busy", {31'd0, busy}, 32'd0);
        chk("midreset.done", {31'd0, done}, 32'd0);
        chk("midreset.result", {16'd0, result}, 32'd0);
        chk("midreset.flags", {28'd0, flags}, 32'd0);
        chk("midreset.div_zero", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue("after_reset", 16'h1234, 8'h56, 16'h1036, F_NONE, 1'b0, 1'b0);

        wait_idle("final");
        repeat (4) @(negedge clk);
        chk("hold.result", {16'd0, result}, 32'h0000_1036);
        chk("hold.flags", {28'd0, flags}, {28'd0, F_NONE});
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Sequential unsigned 16÷8 divider for the S1C88 CPU core. It is the iterative inverse counterpart of the combinational ALU's 8×8 MUL path.
- The CPU sequencer hands it the dividend (HL) and divisor (A). The block returns {remainder, quotient} plus the Z/C/V/S flag nibble in the same bit order the ALU uses. The sequencer then writes the result back to HL and the flag register.
- It replaces the single-cycle DIV path, which is too deep for timing. Restoring algorithm, one quotient bit per clock.

Parameters:
- None. Widths are fixed by the ISA.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a divide; sampled only in IDLE
- dividend  in  16  unsigned dividend (HL)
- divisor  in  8  unsigned divisor (A)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; result, flags and div_zero are valid in this cycle
- result  out  16  {remainder[7:0], quotient[7:0]}, or the unmodified dividend on overflow or divide-by-zero
- flags  out  4  bit0 Z, bit1 C, bit2 V, bit3 S
- div_zero  out  1  pulses together with done when divisor == 0; drives the CPU exception logic

Behaviour:
- Reset: asynchronous, active-low. Every register clears immediately: state=IDLE, busy=0, done=0, div_zero=0, result=0, flags=0. Reset asserted mid-divide abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at clock edge k: latch dividend and divisor, then choose one of three paths.
  - divisor==0: next state DONE. result=dividend; flags Z=0, C=0, V=1, S=1; div_zero=1.
  - dividend[15:8] >= divisor (quotient cannot fit in 8 bits): next state DONE. result=dividend; flags Z=0, C=0, V=1, S=1; div_zero=0.
  - Otherwise: next state RUN. Partial remainder prem[7:0]=dividend[15:8]; shift register holds dividend[7:0]; step counter=7.
- RUN, one step per cycle (8 cycles):
  - Form t[8:0] = {prem, next dividend bit, MSB first}.
  - If t >= {1'b0, divisor}: prem=t-divisor, shift in quotient bit 1. Else prem=t[7:0], shift in 0.
  - t-divisor always fits in 8 bits because the prem<divisor invariant holds.
  - The counter decrements each step. On the step where counter==0, go to DONE.
- DONE (normal path): result={prem, quotient}. Flags: Z=(quotient==0), C=0, V=0, S=quotient[7].
- DONE lasts exactly one cycle: done=1, busy=1. Next state is IDLE unconditionally.
- done and div_zero are registered. They are high only in the DONE cycle.
- result and flags hold their last value until the next DONE. The sequencer may sample them late.
- Latency, with start sampled at edge k:
  - Fast path (divide-by-zero or overflow): done high in cycle k+1.
  - Normal path: busy high in cycles k+1..k+9; done high in cycle k+9.
- start while busy, including the DONE cycle, is ignored and not queued. Back-to-back operation is start in the first IDLE cycle after DONE.
- Operands are captured at start. Input changes while busy have no effect.
- No X propagation: the divisor==0 check precedes any compare.

Decomposition:
- Shared package alu_pkg holds:
  - the flag-index enum (ALU_FLAG_Z=0, C=1, V=2, S=3), shared with the ALU and flag register;
  - the divider state enum (IDLE, RUN, DONE).
- One sub-module is natural: alu_div_step. It is combinational: inputs prem[7:0], in_bit, divisor[7:0]; outputs new_prem[7:0], q_bit. This lets a future radix-4 variant instantiate it twice per cycle.

Test Plan:
- 0x1234 ÷ 0x56 -> done at k+9; result=0x1036 (q=0x36, r=0x10); flags Z=0, C=0, V=0, S=0; div_zero=0.
- 0xFEFF ÷ 0xFF -> done at k+9; result=0xFEFF (q=0xFF, r=0xFE); S=1, Z=0, V=0.
- 0x0005 ÷ 0x07 -> result=0x0500; Z=1, S=0. Then 0x5600 ÷ 0x56 -> overflow, done at k+1; result=0x5600; V=1, S=1, Z=0; div_zero=0.
- 0x1234 ÷ 0x00 -> done and div_zero both pulse at k+1; result=0x1234; V=1, S=1, Z=0, C=0.
- start held high continuously with changing operands -> exactly one divide per IDLE visit. Operands changed at k+3 do not alter the result. Each done is a single-cycle pulse.
- Assert reset_n low in cycle k+4 of a normal divide -> busy=0, result=0, flags=0 immediately; no done. Release, start 0x1234 ÷ 0x56 -> correct 0x1036 at k'+9.
